// File: rtl/result_summarizer.sv
// Scans both result RAMs over a shared read address and reduces them to
// summary statistics: signed sum/min/max and zero count of RAM0 (signed
// differences), unsigned sum/max of RAM1 (magnitudes). Results are held
// after done until the next accepted start.
module result_summarizer #(
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WORDS  = 512,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                   CLOCK_50_I,
  input  logic                                   resetn,
  input  logic                                   start,
  output logic        [ADDR_WIDTH-1:0]           rd_address,
  input  logic        [DATA_WIDTH-1:0]           rd_data0,
  input  logic        [DATA_WIDTH-1:0]           rd_data1,
  output logic                                   busy,
  output logic                                   done,
  output logic signed [DATA_WIDTH+ADDR_WIDTH-1:0] sum0,
  output logic signed [DATA_WIDTH-1:0]           min0,
  output logic signed [DATA_WIDTH-1:0]           max0,
  output logic        [ADDR_WIDTH:0]             zero_count0,
  output logic        [DATA_WIDTH+ADDR_WIDTH-1:0] sum1,
  output logic        [DATA_WIDTH-1:0]           max1
);

  localparam int SUM_W = DATA_WIDTH + ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t state, state_n;

  // vld_p0: rd_address holds a word to read; vld_p1: RAM q holds that word
  logic vld_p0;
  logic vld_p1;
  logic first_flag;

  logic run_start;
  logic scan_end;
  logic drain_end;

  logic signed [DATA_WIDTH-1:0] word0_p1;
  logic        [DATA_WIDTH-1:0] word1_p1;

  assign word0_p1 = rd_data0;
  assign word1_p1 = rd_data1;

  // Two's-complement word widened to the running-sum width
  function automatic logic signed [SUM_W-1:0] sext_word(input logic signed [DATA_WIDTH-1:0] d);
    return {{ADDR_WIDTH{d[DATA_WIDTH-1]}}, d};
  endfunction

  // Unsigned word widened to the running-sum width
  function automatic logic [SUM_W-1:0] zext_word(input logic [DATA_WIDTH-1:0] d);
    return {{ADDR_WIDTH{1'b0}}, d};
  endfunction

  // State register
  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  // Next-state logic; drain finishes once both valid stages are empty
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_SCAN;
      S_SCAN:  if (rd_address == LAST_ADDR) state_n = S_DRAIN;
      S_DRAIN: if (!vld_p0 && !vld_p1) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    run_start = 1'b0;
    scan_end  = 1'b0;
    drain_end = 1'b0;
    case (state)
      S_IDLE:  run_start = start;
      S_SCAN:  scan_end  = (rd_address == LAST_ADDR);
      S_DRAIN: drain_end = !vld_p0 && !vld_p1;
      default: ;
    endcase
  end

  // Address counter, valid pipe and handshake flags
  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) begin
      rd_address <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      done   <= drain_end;
      if (run_start) begin
        rd_address <= '0;
        vld_p0     <= 1'b1;
        busy       <= 1'b1;
      end else if (state == S_SCAN) begin
        if (scan_end) vld_p0 <= 1'b0;
        else          rd_address <= rd_address + 1'b1;
      end
      if (drain_end) busy <= 1'b0;
    end
  end

  // Accumulators: cleared on an accepted start, updated when a word reaches stage p1
  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) begin
      sum0        <= '0;
      min0        <= '0;
      max0        <= '0;
      zero_count0 <= '0;
      sum1        <= '0;
      max1        <= '0;
      first_flag  <= 1'b0;
    end else if (run_start) begin
      sum0        <= '0;
      min0        <= '0;
      max0        <= '0;
      zero_count0 <= '0;
      sum1        <= '0;
      max1        <= '0;
      first_flag  <= 1'b1;
    end else if (vld_p1) begin
      sum0        <= sum0 + sext_word(word0_p1);
      sum1        <= sum1 + zext_word(word1_p1);
      zero_count0 <= zero_count0 + CNT_W'(word0_p1 == '0);
      first_flag  <= 1'b0;
      if (first_flag) begin
        min0 <= word0_p1;
        max0 <= word0_p1;
        max1 <= word1_p1;
      end else begin
        if (word0_p1 < min0) min0 <= word0_p1;
        if (word0_p1 > max0) max0 <= word0_p1;
        if (word1_p1 > max1) max1 <= word1_p1;
      end
    end
  end

endmodule

// File: tb/tb_result_summarizer.sv
// Bench for result_summarizer: behavioural RAMs feed the DUT, a reference
// model reduces the RAM contents with plain loops, and each run is checked
// for latency, single done pulse, address sequence and the summary values.
module tb_result_summarizer;

  localparam int NW = 512;

  logic               clk;
  logic               resetn;
  logic               start;
  logic [8:0]         rd_address;
  logic [7:0]         rd_data0;
  logic [7:0]         rd_data1;
  logic               busy;
  logic               done;
  logic signed [16:0] sum0;
  logic signed [7:0]  min0;
  logic signed [7:0]  max0;
  logic [9:0]         zero_count0;
  logic [16:0]        sum1;
  logic [7:0]         max1;

  logic [7:0] ram0 [NW];
  logic [7:0] ram1 [NW];

  int checks = 0;
  int errors = 0;

  int e_sum0, e_min0, e_max0, e_zc, e_sum1, e_max1;

  result_summarizer #(.ADDR_WIDTH(9), .NUM_WORDS(NW), .DATA_WIDTH(8)) dut (
    .CLOCK_50_I  (clk),
    .resetn      (resetn),
    .start       (start),
    .rd_address  (rd_address),
    .rd_data0    (rd_data0),
    .rd_data1    (rd_data1),
    .busy        (busy),
    .done        (done),
    .sum0        (sum0),
    .min0        (min0),
    .max0        (max0),
    .zero_count0 (zero_count0),
    .sum1        (sum1),
    .max1        (max1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Synchronous-read RAMs
  always @(posedge clk) begin
    rd_data0 <= ram0[rd_address];
    rd_data1 <= ram1[rd_address];
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: statistics straight from the RAM contents
  task automatic model();
    byte b;
    int v, u;
    e_sum0 = 0; e_sum1 = 0; e_zc = 0;
    e_min0 = 127; e_max0 = -128; e_max1 = 0;
    for (int k = 0; k < NW; k++) begin
      b = ram0[k];
      v = b;
      u = int'(ram1[k]);
      e_sum0 += v;
      e_sum1 += u;
      if (v == 0) e_zc++;
      if (v < e_min0) e_min0 = v;
      if (v > e_max0) e_max0 = v;
      if (u > e_max1) e_max1 = u;
    end
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < NW; k++) begin
      case (mode)
        0: begin ram0[k] = 8'h80; ram1[k] = 8'hFF; end
        1: begin ram0[k] = k[7:0]; ram1[k] = k[7:0]; end
        2: begin ram0[k] = 8'h00; ram1[k] = 8'h00; end
        3: begin
             ram0[k] = (k == NW-1) ? 8'hFE : 8'h01;
             ram1[k] = (k == 0) ? 8'h05 : 8'h00;
           end
        4: begin ram0[k] = 8'($urandom); ram1[k] = 8'($urandom); end
        default: begin
             ram0[k] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
             ram1[k] = 8'($urandom_range(0, 40));
           end
      endcase
    end
  endtask

  task automatic do_run(input string tag, input bit glitch);
    int cnt, done_at, ndone, steps, bad;
    logic [8:0] prev;
    model();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk({tag, "_addr0"}, rd_address, 0);
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_sum0_clr"}, sum0, 0);
    chk({tag, "_zc_clr"}, zero_count0, 0);
    prev = rd_address; steps = 0; bad = 0; cnt = 0; done_at = -1; ndone = 0;
    while (cnt < 600) begin
      @(posedge clk); cnt++; #1;
      start = glitch && (cnt == 10 || cnt == 300);
      if (rd_address != prev) begin
        if (rd_address != prev + 9'd1) bad++;
        steps++;
        prev = rd_address;
      end
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = cnt;
      end
    end
    chk({tag, "_done_edge"}, done_at, 514);
    chk({tag, "_done_count"}, ndone, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_addr_steps"}, steps, NW - 1);
    chk({tag, "_addr_gaps"}, bad, 0);
    chk({tag, "_addr_last"}, rd_address, NW - 1);
    chk({tag, "_sum0"}, longint'(sum0), e_sum0);
    chk({tag, "_min0"}, longint'(min0), e_min0);
    chk({tag, "_max0"}, longint'(max0), e_max0);
    chk({tag, "_zc0"}, zero_count0, e_zc);
    chk({tag, "_sum1"}, sum1, e_sum1);
    chk({tag, "_max1"}, max1, e_max1);
  endtask

  initial begin
    int nd;
    resetn = 1'b0;
    start  = 1'b0;
    fill(2);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", rd_address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum0", sum0, 0);
    chk("rst_sum1", sum1, 0);
    chk("rst_max1", max1, 0);
    @(negedge clk); resetn = 1'b1;

    fill(0); do_run("neg_full", 1'b0);
    chk("neg_full_sum0_const", longint'(sum0), -65536);
    fill(1); do_run("ramp", 1'b0);
    chk("ramp_sum0_const", longint'(sum0), -256);
    fill(2); do_run("zeros", 1'b0);
    fill(3); do_run("outlier", 1'b0);
    chk("outlier_sum0_const", longint'(sum0), 509);
    fill(4); do_run("rand_glitch", 1'b1);
    do_run("rand_clean", 1'b0);

    // Abort a scan with reset, then rerun on fresh data
    fill(4);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk); resetn = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_addr", rd_address, 0);
    chk("abort_sum1", sum1, 0);
    @(negedge clk); resetn = 1'b1;
    nd = 0;
    repeat (600) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    fill(5); do_run("after_abort", 1'b0);

    for (int r = 0; r < 3; r++) begin
      fill(4 + (r % 2));
      do_run("rand_loop", 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
